// File: rtl/mseq_pkg.sv
// Shared state encodings, counter width and saturating-increment helper for the
// m-sequence checker.
package mseq_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != {CNT_W{1'b1}})) begin
         return v + 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/m_sequence_pred.sv
// LFSR history and next-bit prediction; the caller chooses whether the received
// or the predicted bit is shifted in (newest bit enters at the MSB).
module m_sequence_pred #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [DATA_WIDTH-1:0] seed_i,
   input  logic                  shift_i,
   input  logic                  sel_pred_i,
   input  logic                  rx_bit_i,
   output logic                  pred_o,
   output logic                  hist_zero_o
);

   logic [DATA_WIDTH-1:0] hist_q, hist_d;
   logic [DATA_WIDTH-1:0] seed_q;
   logic                  shift_bit;

   assign pred_o      = ^(hist_q & seed_q);
   assign hist_zero_o = (hist_q == '0);
   assign shift_bit   = sel_pred_i ? pred_o : rx_bit_i;

   always_comb begin
      hist_d = hist_q;
      if (shift_i) begin
         hist_d = {shift_bit, hist_q[DATA_WIDTH-1:1]};
      end
   end

   // The tap mask is only captured while reset is held.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         hist_q <= '0;
         seed_q <= seed_i;
      end else begin
         hist_q <= hist_d;
      end
   end

endmodule

// File: rtl/m_sequence_checker.sv
// Serial m-sequence checker: hunts for LFSR alignment, verifies it, then counts
// bit errors against a self-generated reference with windowed loss-of-lock.
module m_sequence_checker
   import mseq_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LOCK_COUNT = 32,
   parameter int ERR_WINDOW = 64,
   parameter int ERR_LIMIT  = 8
) (
   input  logic                  MCHK_clk,
   input  logic                  MCHK_rst_n,
   input  logic [DATA_WIDTH-1:0] MCHK_seed,
   input  logic                  MCHK_data_in,
   input  logic                  MCHK_data_valid,
   input  logic                  MCHK_clr_cnt,
   output logic                  MCHK_locked,
   output logic                  MCHK_err,
   output logic [CNT_W-1:0]      MCHK_err_count,
   output logic [CNT_W-1:0]      MCHK_bit_count
);

   localparam int FILL_W  = $clog2(DATA_WIDTH + 1);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int WIN_W   = $clog2(ERR_WINDOW + 1);
   localparam int WERR_W  = $clog2(ERR_LIMIT + 1);

   state_e              state_q, state_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [MATCH_W-1:0]  match_q, match_d;
   logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
   logic [WERR_W-1:0]   win_err_q, win_err_d;
   logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]    err_base, bit_base;
   logic                err_q, err_d;
   logic                locked_q, locked_d;

   logic                shift, sel_pred, pred, hist_zero, mismatch, checked, err_hit;

   m_sequence_pred #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_pred (
      .clk_i       (MCHK_clk),
      .rst_n_i     (MCHK_rst_n),
      .seed_i      (MCHK_seed),
      .shift_i     (shift),
      .sel_pred_i  (sel_pred),
      .rx_bit_i    (MCHK_data_in),
      .pred_o      (pred),
      .hist_zero_o (hist_zero)
   );

   assign mismatch = pred ^ MCHK_data_in;

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      match_d   = match_q;
      win_cnt_d = win_cnt_q;
      win_err_d = win_err_q;
      shift     = 1'b0;
      sel_pred  = 1'b0;
      checked   = 1'b0;
      err_hit   = 1'b0;
      if (MCHK_data_valid) begin
         shift = 1'b1;
         case (state_q)
            HUNT: begin
               if (fill_q == FILL_W'(DATA_WIDTH - 1)) begin
                  state_d = VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
            VERIFY: begin
               if (mismatch) begin
                  state_d = HUNT;
                  fill_d  = '0;
                  match_d = '0;
               end else if (!hist_zero) begin
                  // An all-zero history predicts zeros forever; it must not earn lock.
                  if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                     state_d = LOCKED;
                     match_d = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end
            end
            LOCKED: begin
               sel_pred = 1'b1;
               checked  = 1'b1;
               err_hit  = mismatch;
               if (mismatch && (win_err_q == WERR_W'(ERR_LIMIT - 1))) begin
                  state_d   = HUNT;
                  fill_d    = '0;
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else if (win_cnt_q == WIN_W'(ERR_WINDOW - 1)) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + 1'b1;
                  win_err_d = win_err_q + WERR_W'(mismatch);
               end
            end
            default: begin
               state_d = HUNT;
               fill_d  = '0;
            end
         endcase
      end
   end

   // Clear zeroes first, so a coincident hit lands as a count of one.
   always_comb begin
      err_base  = MCHK_clr_cnt ? '0 : err_cnt_q;
      bit_base  = MCHK_clr_cnt ? '0 : bit_cnt_q;
      err_cnt_d = sat_inc(err_base, err_hit);
      bit_cnt_d = sat_inc(bit_base, checked);
      err_d     = err_hit;
      locked_d  = (state_d == LOCKED);
   end

   always_ff @(posedge MCHK_clk) begin
      if (!MCHK_rst_n) begin
         state_q   <= HUNT;
         fill_q    <= '0;
         match_q   <= '0;
         win_cnt_q <= '0;
         win_err_q <= '0;
         err_cnt_q <= '0;
         bit_cnt_q <= '0;
         err_q     <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         win_cnt_q <= win_cnt_d;
         win_err_q <= win_err_d;
         err_cnt_q <= err_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         err_q     <= err_d;
         locked_q  <= locked_d;
      end
   end

   assign MCHK_locked    = locked_q;
   assign MCHK_err       = err_q;
   assign MCHK_err_count = err_cnt_q;
   assign MCHK_bit_count = bit_cnt_q;

endmodule

// File: doc/m_sequence_checker.md
M_SEQUENCE_CHECKER -- requirements
Module: m_sequence_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets LFSR length; must equal the generator's width.
REQ-002 Parameter LOCK_COUNT, default 32, sets the number of consecutive matching bits required to declare lock.
REQ-003 Parameter ERR_WINDOW, default 64, sets the window length in valid bits used for loss-of-lock.
REQ-004 Parameter ERR_LIMIT, default 8, sets the error count within one window that forces loss of lock.
REQ-005 MCHK_clk  in  1  sole clock; all logic on rising edge.
REQ-006 MCHK_rst_n  in  1  reset, synchronous, active-low.
REQ-007 MCHK_seed  in  DATA_WIDTH  tap mask, same meaning as the generator seed.
REQ-008 MCHK_data_in  in  1  received serial bit.
REQ-009 MCHK_data_valid  in  1  qualifies MCHK_data_in; bit consumed only when high.
REQ-010 MCHK_clr_cnt  in  1  clears the error and bit counters.
REQ-011 MCHK_locked  out  1  high while in LOCKED.
REQ-012 MCHK_err  out  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-013 MCHK_err_count  out  32  saturating count of bit errors.
REQ-014 MCHK_bit_count  out  32  saturating count of bits checked while LOCKED.

Function
REQ-015 Stream model: bit s[n+W] = XOR over i of (seed[i] AND s[n+i]), where W = DATA_WIDTH; hist[i] holds s[n+i], the newest bit is at the MSB, and each step shifts right.
REQ-016 The predicted bit shall be ^(hist & seed_reg); seed_reg is latched from MCHK_seed only while reset is low.
REQ-017 States: HUNT, VERIFY, LOCKED; with MCHK_data_valid low, all state, history and counters hold.
REQ-018 HUNT: each valid bit shifts into hist and increments fill count; after W valid bits, go to VERIFY with match count 0.
REQ-019 VERIFY: each valid bit shifts the received bit into hist.
REQ-020 VERIFY, match: increment the match count; when it reaches LOCK_COUNT, go to LOCKED.
REQ-021 VERIFY, mismatch: go to HUNT with fill count 0; hist keeps its contents.
REQ-022 A hist of all zeros shall never advance VERIFY to LOCKED; the state stays in VERIFY and the match count holds at 0.
REQ-023 LOCKED: hist is self-generated (the predicted bit is shifted in) so received errors do not propagate.
REQ-024 LOCKED: each valid bit increments MCHK_bit_count; a mismatch pulses MCHK_err and increments MCHK_err_count.
REQ-025 Window counter runs in LOCKED only and restarts every ERR_WINDOW valid bits, clearing the window error count.
REQ-026 When the window error count reaches ERR_LIMIT, go to HUNT with fill count 0.
REQ-027 MCHK_locked falls on the same edge as the transition.
REQ-028 Output latency: MCHK_locked, MCHK_err and both counters are registered and update on the edge that consumes the bit.
REQ-029 Counters saturate at 32'hFFFF_FFFF and do not wrap.
REQ-030 MCHK_clr_cnt zeroes both counters.
REQ-031 If an error and MCHK_clr_cnt occur in the same cycle, MCHK_err_count becomes 1 and MCHK_bit_count becomes 1.
REQ-032 MCHK_clr_cnt does not affect state or the window logic.

Reset
REQ-033 Reset state: HUNT, with hist, fill count, match count and window counters all zero.
REQ-034 Reset outputs: MCHK_locked=0, MCHK_err=0, MCHK_err_count=0, MCHK_bit_count=0.
REQ-035 Reset asserted in any state, including mid-LOCKED, shall take effect on the next edge with no residual pulse.

Structure
REQ-036 A shared package mseq_pkg shall hold the state encodings (HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2) and the counter width constant (32).
REQ-037 One sub-module, m_sequence_pred, shall hold hist, seed_reg and the prediction XOR.
REQ-038 m_sequence_pred shall select its shift-in source (received or predicted bit) from a control input.
REQ-039 Total RTL shall be 120-400 lines.

Verification
REQ-040 Clean stream: DATA_WIDTH=16, seed 16'h002D, generator init 16'h0001, valid always high -> MCHK_locked rises exactly 48 valid bits after the first bit, and MCHK_err_count stays 0.
REQ-041 Single flip: invert one bit while LOCKED -> exactly one MCHK_err pulse, MCHK_err_count=1, MCHK_locked stays 1.
REQ-042 Burst: 8 flipped bits within 64 -> MCHK_locked drops on the 8th error, then relocks after 48 further clean bits.
REQ-043 Zeros and gaps: all-zero input never locks; a random valid duty of 50% on a clean stream -> lock after 48 valid bits, unchanged.
REQ-044 Clear: MCHK_clr_cnt coincident with an error -> MCHK_err_count=1; preload near saturation -> count holds at 32'hFFFF_FFFF.
REQ-045 Reset mid-LOCKED: assert MCHK_rst_n=0 for one cycle -> all outputs 0 on the next edge and the state returns to HUNT.
